// File: rtl/spi_peripheral.sv
// spi_peripheral: mode-0 SPI target, MSB first, full duplex.
// Oversamples sck/mosi/cs_n on clk; one-deep tx buffer, rx word out.
module spi_peripheral #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_s_q;
  logic [SYNC_STAGES-1:0] mosi_s_q;
  logic [SYNC_STAGES-1:0] cs_s_q;
  logic                   sck_d1_q;
  logic                   cs_d1_q;
  logic [SYNC_STAGES:0]   fill_q;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    tx_shift_q;
  logic [W-2:0]    rx_shift_q;
  logic [W-1:0]    rx_data_q;
  logic            rx_valid_q;
  logic            tx_underrun_q;
  logic            miso_q;
  logic            miso_oe_q;
  logic            busy_q;
  logic [W-1:0]    buf_q;
  logic            buf_full_q;

  logic            sck_l;
  logic            mosi_l;
  logic            cs_l;
  logic            sck_rise;
  logic            sck_fall;
  logic            cs_rise;
  logic            cs_fall;
  logic            accept;
  logic            reload;
  logic [W-1:0]    load_word_d;
  logic [W-1:0]    rx_word_d;

  assign sck_l  = sck_s_q[SYNC_STAGES-1];
  assign mosi_l = mosi_s_q[SYNC_STAGES-1];
  assign cs_l   = cs_s_q[SYNC_STAGES-1];

  assign sck_rise = sck_l & ~sck_d1_q;
  assign sck_fall = ~sck_l & sck_d1_q;
  assign cs_rise  = cs_l & ~cs_d1_q;
  // fill_q hides the fake cs_n fall that a low cs_n makes right after reset
  assign cs_fall  = ~cs_l & cs_d1_q & fill_q[SYNC_STAGES];

  assign accept      = tx_valid & ~buf_full_q;
  assign load_word_d = buf_full_q ? buf_q : '0;
  assign rx_word_d   = {rx_shift_q, mosi_l};

  assign reload = ((state_q == IDLE) & cs_fall) |
                  ((state_q == ACTIVE) & ~cs_rise &
                   sck_fall & (cnt_q == '0));

  // Input synchronizers, edge delay flops and post-reset settle tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s_q  <= '0;
      mosi_s_q <= '0;
      cs_s_q   <= '1;
      sck_d1_q <= 1'b0;
      cs_d1_q  <= 1'b1;
      fill_q   <= '0;
    end else begin
      sck_s_q  <= {sck_s_q[SYNC_STAGES-2:0], sck};
      mosi_s_q <= {mosi_s_q[SYNC_STAGES-2:0], mosi};
      cs_s_q   <= {cs_s_q[SYNC_STAGES-2:0], cs_n};
      sck_d1_q <= sck_l;
      cs_d1_q  <= cs_l;
      fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // One-deep tx buffer; a reload sees the pre-cycle contents
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (accept) begin
      buf_q      <= tx_data;
      buf_full_q <= 1'b1;
    end else if (reload) begin
      buf_full_q <= 1'b0;
    end
  end

  // Frame FSM: select tracking, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      if (reload) begin
        tx_shift_q    <= load_word_d;
        miso_q        <= load_word_d[W-1];
        tx_underrun_q <= ~buf_full_q;
      end
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ACTIVE;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            miso_oe_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
          end else if (sck_rise) begin
            rx_shift_q <= rx_word_d[W-2:0];
            if (cnt_q == LAST) begin
              cnt_q      <= '0;
              rx_data_q  <= rx_word_d;
              rx_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (sck_fall && cnt_q != '0) begin
            tx_shift_q <= tx_shift_q << 1;
            miso_q     <= tx_shift_q[W-2];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed frames from a mode-0 controller model,
// transaction-level tx/rx model and a per-cycle compare process.
module tb_spi_peripheral;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck, mosi, cs_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       miso, miso_oe, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, busy;

  always #5 clk = ~clk;

  spi_peripheral #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model
  logic [7:0] mq[$];
  logic       pend_v;
  logic [7:0] pend_w;
  logic [7:0] cur_tx;
  int         exp_under = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] mdl_rx;
  int         seen_rx = 0;
  int         seen_under = 0;
  bit         sel_win = 0;
  bit         idle_win = 0;
  logic [7:0] offer_w;
  event       tx_go;
  logic [7:0] got;

  task automatic frame_start();
    if (mq.size() > 0) cur_tx = mq.pop_front();
    else begin
      cur_tx = 8'h00;
      exp_under++;
    end
    if (pend_v) begin
      mq.push_back(pend_w);
      pend_v = 1'b0;
    end
  endtask

  task automatic offer(input logic [7:0] w);
    if (mq.size() == 0) mq.push_back(w);
    else begin
      pend_v = 1'b1;
      pend_w = w;
    end
    offer_w = w;
    -> tx_go;
  endtask

  // tx handshake driver
  initial begin
    bit ok;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(tx_go);
      tx_data  = offer_w;
      tx_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if (tx_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) chk("tx_accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
    end
  end

  // per-cycle compare process
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (rx_valid) begin
          seen_rx++;
          if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
          else begin
            mdl_rx = exp_rx.pop_front();
            chk("rx_data", rx_data, mdl_rx);
          end
        end else begin
          chk("rx_hold", rx_data, mdl_rx);
        end
        if (tx_underrun) seen_under++;
        if (sel_win) begin
          chk("busy_sel", busy, 1);
          chk("oe_sel", miso_oe, 1);
        end
        if (idle_win) begin
          chk("busy_idle", busy, 0);
          chk("oe_idle", miso_oe, 0);
          chk("miso_idle", miso, 0);
        end
      end
    end
  end

  task automatic cs_low();
    cs_n = 1'b0;
    idle_win = 1'b0;
    frame_start();
    repeat (HALF) @(negedge clk);
    sel_win = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] mo, input int nbits,
                           input bit end_cs, input int offer_at,
                           input logic [7:0] ow, output logic [7:0] g);
    g = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i == offer_at) offer(ow);
      mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      g[7-i] = miso;
      chk("miso_bit", miso, cur_tx[7-i]);
      chk("tx_ready", tx_ready, mq.size() == 0);
      sck = 1'b1;
      if (i == 7) exp_rx.push_back(mo);
      repeat (HALF) @(negedge clk);
      if (i == nbits - 1 && end_cs) begin
        cs_n = 1'b1;
        sel_win = 1'b0;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        repeat (HALF) @(negedge clk);
        idle_win = 1'b1;
      end else begin
        sck = 1'b0;
        if (i == 7) frame_start();
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_oe"}, miso_oe, 0);
    chk({tag, "_rxd"}, rx_data, 0);
    chk({tag, "_rxv"}, rx_valid, 0);
    chk({tag, "_undr"}, tx_underrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, tx_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    pend_v = 1'b0; mdl_rx = 8'h00; cur_tx = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    idle_win = 1'b1;
    repeat (4) @(negedge clk);

    // 1: 0xA5 out, 0x3C in
    offer(8'hA5);
    repeat (3) @(negedge clk);
    chk("t1_rdy_full", tx_ready, 0);
    cs_low();
    send_bits(8'h3C, 8, 1, -1, 8'h00, got);
    chk("t1_miso_word", got, 8'hA5);
    repeat (4) @(negedge clk);
    chk("t1_rx", rx_data, 8'h3C);
    chk("t1_rxcnt", seen_rx, 1);
    chk("t1_under", seen_under, 0);

    // 2: underrun frame
    cs_low();
    send_bits(8'h96, 8, 1, -1, 8'h00, got);
    chk("t2_miso_word", got, 8'h00);
    repeat (4) @(negedge clk);
    chk("t2_rx", rx_data, 8'h96);
    chk("t2_under", seen_under, 1);

    // 3: back-to-back frames under one cs_n
    offer(8'h81);
    repeat (3) @(negedge clk);
    cs_low();
    send_bits(8'h12, 8, 0, 2, 8'h7E, got);
    chk("t3_miso_w0", got, 8'h81);
    send_bits(8'h34, 8, 1, -1, 8'h00, got);
    chk("t3_miso_w1", got, 8'h7E);
    repeat (4) @(negedge clk);
    chk("t3_rx", rx_data, 8'h34);
    chk("t3_rxcnt", seen_rx, 4);
    chk("t3_under", seen_under, 1);

    // 4: abort after 5 bits, then clean frame
    cs_low();
    send_bits(8'hFF, 5, 1, -1, 8'h00, got);
    repeat (4) @(negedge clk);
    chk("t4_rxcnt_abort", seen_rx, 4);
    cs_low();
    send_bits(8'hF0, 8, 1, -1, 8'h00, got);
    repeat (4) @(negedge clk);
    chk("t4_rx", rx_data, 8'hF0);
    chk("t4_rxcnt", seen_rx, 5);

    // 5: reset mid-frame with cs_n held low
    cs_low();
    send_bits(8'hAA, 3, 0, -1, 8'h00, got);
    rst = 1'b1;
    sel_win = 1'b0;
    idle_win = 1'b0;
    mq.delete();
    exp_rx.delete();
    pend_v = 1'b0;
    mdl_rx = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst1");
    rst = 1'b0;
    idle_win = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    chk("t5_busy_after", busy, 0);
    chk("t5_rxcnt_idle", seen_rx, 5);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    cs_low();
    send_bits(8'hA7, 8, 1, -1, 8'h00, got);
    repeat (4) @(negedge clk);
    chk("t5_rx", rx_data, 8'hA7);
    chk("t5_rxcnt", seen_rx, 6);
    chk("t5_under", seen_under, 5);

    // 6: offer held against a full buffer
    offer(8'h5A);
    repeat (3) @(negedge clk);
    offer(8'hC3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_rdy_full", tx_ready, 0);
    end
    cs_low();
    send_bits(8'h11, 8, 1, -1, 8'h00, got);
    chk("t6_miso_old", got, 8'h5A);
    repeat (4) @(negedge clk);
    cs_low();
    send_bits(8'h22, 8, 1, -1, 8'h00, got);
    chk("t6_miso_new", got, 8'hC3);
    repeat (4) @(negedge clk);
    chk("t6_rx", rx_data, 8'h22);
    chk("t6_rxcnt", seen_rx, 8);
    chk("t6_under", seen_under, 5);
    chk("under_model", seen_under, exp_under);
    chk("rx_left", exp_rx.size(), 0);
    chk("t6_rdy_end", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
